// File: rtl/conv_frame_tx.sv
// Transmit-side video framer: wraps a raw pixel stream into AXI4-Stream beats
// with tuser on the first pixel of a frame and tlast on the last pixel of each line.
module conv_frame_tx #(
    parameter int unsigned  PIXEL_W    = 8,
    parameter int unsigned  MAX_WIDTH  = 1920,
    parameter int unsigned  MAX_HEIGHT = 1080,
    localparam int unsigned W_W        = $clog2(MAX_WIDTH + 1),
    localparam int unsigned H_W        = $clog2(MAX_HEIGHT + 1)
) (
    input  logic               clk_i,
    input  logic               arst_i,
    input  logic               start_i,
    input  logic [W_W-1:0]     cfg_width_i,
    input  logic [H_W-1:0]     cfg_height_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    input  logic               pix_valid_i,
    input  logic [PIXEL_W-1:0] pix_data_i,
    output logic               pix_ready_o,
    input  logic               m_tready_i,
    output logic               m_tvalid_o,
    output logic [PIXEL_W-1:0] m_tdata_o,
    output logic               m_tuser_o,
    output logic               m_tlast_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [W_W-1:0]     r_width;
    logic [H_W-1:0]     r_height;
    logic [W_W-1:0]     r_col;
    logic [H_W-1:0]     r_row;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic               r_pix_ready;

    logic               r_out_valid;
    logic [PIXEL_W-1:0] r_out_data;
    logic               r_out_user;
    logic               r_out_last;
    logic               r_skid_valid;
    logic [PIXEL_W-1:0] r_skid_data;
    logic               r_skid_user;
    logic               r_skid_last;

    logic               w_acc;
    logic               w_pop;
    logic               w_cfg_ok;
    logic               w_start_ok;
    logic               w_last_col;
    logic               w_last_row;
    logic               w_last_pix;
    logic               w_final_pop;
    logic               w_in_user;

    logic [W_W-1:0]     w_width_nxt;
    logic [H_W-1:0]     w_height_nxt;
    logic [W_W-1:0]     w_col_nxt;
    logic [H_W-1:0]     w_row_nxt;
    logic               w_out_valid_nxt;
    logic [PIXEL_W-1:0] w_out_data_nxt;
    logic               w_out_user_nxt;
    logic               w_out_last_nxt;
    logic               w_skid_valid_nxt;
    logic [PIXEL_W-1:0] w_skid_data_nxt;
    logic               w_skid_user_nxt;
    logic               w_skid_last_nxt;

    assign w_acc       = pix_valid_i & r_pix_ready;
    assign w_pop       = r_out_valid & m_tready_i;
    assign w_cfg_ok    = (cfg_width_i != '0) && (cfg_width_i <= W_W'(MAX_WIDTH)) &&
                         (cfg_height_i != '0) && (cfg_height_i <= H_W'(MAX_HEIGHT));
    assign w_start_ok  = (r_state == S_IDLE) & start_i & w_cfg_ok;
    assign w_last_col  = (r_col == r_width - W_W'(1));
    assign w_last_row  = (r_row == r_height - H_W'(1));
    assign w_last_pix  = w_last_col & w_last_row;
    assign w_in_user   = (r_col == '0) && (r_row == '0);
    // Once in DRAIN no input is accepted, so an empty skid means the output holds the final beat.
    assign w_final_pop = (r_state == S_DRAIN) & w_pop & ~r_skid_valid;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok)          w_state_nxt = S_FILL;
            S_FILL:  if (w_acc && w_last_pix) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_final_pop)         w_state_nxt = S_IDLE;
            default:                          w_state_nxt = S_IDLE;
        endcase
    end

    // Frame counters and per-frame geometry.
    always_comb begin
        w_width_nxt  = r_width;
        w_height_nxt = r_height;
        w_col_nxt    = r_col;
        w_row_nxt    = r_row;
        if (w_start_ok) begin
            w_width_nxt  = cfg_width_i;
            w_height_nxt = cfg_height_i;
            w_col_nxt    = '0;
            w_row_nxt    = '0;
        end else if (w_acc) begin
            if (w_last_col) begin
                w_col_nxt = '0;
                w_row_nxt = r_row + H_W'(1);
            end else begin
                w_col_nxt = r_col + W_W'(1);
            end
        end
    end

    // Output register refills from the skid first, then from the input; otherwise input parks in the skid.
    always_comb begin
        w_out_valid_nxt  = r_out_valid;
        w_out_data_nxt   = r_out_data;
        w_out_user_nxt   = r_out_user;
        w_out_last_nxt   = r_out_last;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_data_nxt  = r_skid_data;
        w_skid_user_nxt  = r_skid_user;
        w_skid_last_nxt  = r_skid_last;
        if (!r_out_valid || w_pop) begin
            if (r_skid_valid) begin
                w_out_valid_nxt  = 1'b1;
                w_out_data_nxt   = r_skid_data;
                w_out_user_nxt   = r_skid_user;
                w_out_last_nxt   = r_skid_last;
                w_skid_valid_nxt = 1'b0;
            end else if (w_acc) begin
                w_out_valid_nxt  = 1'b1;
                w_out_data_nxt   = pix_data_i;
                w_out_user_nxt   = w_in_user;
                w_out_last_nxt   = w_last_col;
            end else begin
                w_out_valid_nxt  = 1'b0;
            end
        end else if (w_acc) begin
            w_skid_valid_nxt = 1'b1;
            w_skid_data_nxt  = pix_data_i;
            w_skid_user_nxt  = w_in_user;
            w_skid_last_nxt  = w_last_col;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_width      <= '0;
            r_height     <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_pix_ready  <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_user   <= 1'b0;
            r_out_last   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_user  <= 1'b0;
            r_skid_last  <= 1'b0;
        end else begin
            r_width      <= w_width_nxt;
            r_height     <= w_height_nxt;
            r_col        <= w_col_nxt;
            r_row        <= w_row_nxt;
            r_busy       <= (w_state_nxt != S_IDLE);
            r_done       <= w_final_pop;
            r_err        <= (r_state == S_IDLE) & start_i & ~w_cfg_ok;
            r_pix_ready  <= (w_state_nxt == S_FILL) & ~w_skid_valid_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_out_data   <= w_out_data_nxt;
            r_out_user   <= w_out_user_nxt;
            r_out_last   <= w_out_last_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_data  <= w_skid_data_nxt;
            r_skid_user  <= w_skid_user_nxt;
            r_skid_last  <= w_skid_last_nxt;
        end
    end

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign pix_ready_o = r_pix_ready;
    assign m_tvalid_o  = r_out_valid;
    assign m_tdata_o   = r_out_data;
    assign m_tuser_o   = r_out_user;
    assign m_tlast_o   = r_out_last;

endmodule

// File: tb/tb_conv_frame_tx.sv
// Directed bench for conv_frame_tx: frame geometry, tagging, backpressure,
// config errors, mid-frame restart and asynchronous reset.
module tb_conv_frame_tx;

    localparam int unsigned PIXEL_W    = 8;
    localparam int unsigned MAX_WIDTH  = 1920;
    localparam int unsigned MAX_HEIGHT = 1080;
    localparam int unsigned W_W        = $clog2(MAX_WIDTH + 1);
    localparam int unsigned H_W        = $clog2(MAX_HEIGHT + 1);

    logic               clk_i = 1'b0;
    logic               arst_i;
    logic               start_i;
    logic [W_W-1:0]     cfg_width_i;
    logic [H_W-1:0]     cfg_height_i;
    logic               busy_o;
    logic               done_o;
    logic               err_o;
    logic               pix_valid_i;
    logic [PIXEL_W-1:0] pix_data_i;
    logic               pix_ready_o;
    logic               m_tready_i;
    logic               m_tvalid_o;
    logic [PIXEL_W-1:0] m_tdata_o;
    logic               m_tuser_o;
    logic               m_tlast_o;

    int checks = 0;
    int errors = 0;

    conv_frame_tx #(
        .PIXEL_W    (PIXEL_W),
        .MAX_WIDTH  (MAX_WIDTH),
        .MAX_HEIGHT (MAX_HEIGHT)
    ) dut (
        .clk_i        (clk_i),
        .arst_i       (arst_i),
        .start_i      (start_i),
        .cfg_width_i  (cfg_width_i),
        .cfg_height_i (cfg_height_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .pix_valid_i  (pix_valid_i),
        .pix_data_i   (pix_data_i),
        .pix_ready_o  (pix_ready_o),
        .m_tready_i   (m_tready_i),
        .m_tvalid_o   (m_tvalid_o),
        .m_tdata_o    (m_tdata_o),
        .m_tuser_o    (m_tuser_o),
        .m_tlast_o    (m_tlast_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},   32'(busy_o),      32'd0);
        chk({tag, "_done"},   32'(done_o),      32'd0);
        chk({tag, "_err"},    32'(err_o),       32'd0);
        chk({tag, "_pready"}, 32'(pix_ready_o), 32'd0);
        chk({tag, "_tvalid"}, 32'(m_tvalid_o),  32'd0);
        chk({tag, "_tdata"},  32'(m_tdata_o),   32'd0);
        chk({tag, "_tuser"},  32'(m_tuser_o),   32'd0);
        chk({tag, "_tlast"},  32'(m_tlast_o),   32'd0);
    endtask

    // mode 0: valid/tready held high; mode 1: tready 1,0,0,1 and random valid gaps.
    task automatic run_frame(input int w, input int h, input int mode, input logic [7:0] base,
                             input int restart_cyc, input int abort_after);
        int                 n_in      = 0;
        int                 n_out     = 0;
        int                 n_done    = 0;
        int                 first_acc = -1;
        int                 last_out  = -1;
        int                 post      = 0;
        bit                 stalled   = 1'b0;
        bit                 timed_out = 1'b1;
        logic [PIXEL_W-1:0] held_d    = '0;
        logic               held_u    = 1'b0;
        logic               held_l    = 1'b0;

        cfg_width_i  = W_W'(w);
        cfg_height_i = H_W'(h);
        start_i      = 1'b1;
        pix_valid_i  = 1'b0;
        m_tready_i   = 1'b0;
        tick();
        start_i = 1'b0;
        chk("busy_after_start", 32'(busy_o), 32'd1);
        for (int cyc = 0; cyc < 2000; cyc++) begin
            pix_valid_i = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
            pix_data_i  = base + PIXEL_W'(n_in);
            m_tready_i  = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            start_i     = (cyc == restart_cyc);
            if (stalled) begin
                chk("stall_tvalid", 32'(m_tvalid_o), 32'd1);
                chk("stall_tdata",  32'(m_tdata_o),  32'(held_d));
                chk("stall_tuser",  32'(m_tuser_o),  32'(held_u));
                chk("stall_tlast",  32'(m_tlast_o),  32'(held_l));
            end
            if (m_tvalid_o && m_tready_i) begin
                chk("beat_tdata", 32'(m_tdata_o), 32'(base + PIXEL_W'(n_out)));
                chk("beat_tuser", 32'(m_tuser_o), 32'(n_out == 0));
                chk("beat_tlast", 32'(m_tlast_o), 32'((n_out % w) == (w - 1)));
                if (mode == 0)
                    chk("beat_timing", 32'(cyc), 32'((n_out == 0) ? first_acc + 1 : last_out + 1));
                if (n_out == w * h - 1)
                    chk("busy_at_final_beat", 32'(busy_o), 32'd1);
                last_out = cyc;
                n_out++;
            end
            stalled = m_tvalid_o && !m_tready_i;
            held_d  = m_tdata_o;
            held_u  = m_tuser_o;
            held_l  = m_tlast_o;
            if (pix_valid_i && pix_ready_o) begin
                if (n_in == 0) first_acc = cyc;
                n_in++;
            end
            if (done_o) begin
                n_done++;
                chk("busy_at_done", 32'(busy_o), 32'd0);
            end
            if (n_done > 0) post++;
            if (post > 3) begin
                timed_out = 1'b0;
                break;
            end
            tick();
            if (abort_after > 0 && n_out == abort_after) begin
                timed_out = 1'b0;
                break;
            end
        end
        start_i     = 1'b0;
        pix_valid_i = 1'b0;
        m_tready_i  = 1'b0;
        chk("frame_timeout", 32'(timed_out), 32'd0);
        if (abort_after > 0) begin
            chk("abort_no_done", 32'(n_done), 32'd0);
        end else begin
            chk("frame_in_count",  32'(n_in),        32'(w * h));
            chk("frame_out_count", 32'(n_out),       32'(w * h));
            chk("frame_done_once", 32'(n_done),      32'd1);
            chk("frame_end_pready", 32'(pix_ready_o), 32'd0);
            chk("frame_end_busy",  32'(busy_o),      32'd0);
        end
    endtask

    initial begin
        arst_i       = 1'b1;
        start_i      = 1'b0;
        cfg_width_i  = '0;
        cfg_height_i = '0;
        pix_valid_i  = 1'b0;
        pix_data_i   = '0;
        m_tready_i   = 1'b0;
        tick();
        tick();
        chk_idle("reset");
        arst_i = 1'b0;
        tick();
        chk_idle("post_reset");

        // 4x2 at full rate
        run_frame(4, 2, 0, 8'h00, -1, 0);

        // single-pixel frame
        run_frame(1, 1, 0, 8'hA5, -1, 0);

        // 3x3 under backpressure and input gaps
        run_frame(3, 3, 1, 8'h10, -1, 0);

        // illegal configs
        cfg_width_i  = W_W'(0);
        cfg_height_i = H_W'(2);
        start_i      = 1'b1;
        tick();
        start_i = 1'b0;
        chk("err_w0_pulse",  32'(err_o),       32'd1);
        chk("err_w0_busy",   32'(busy_o),      32'd0);
        chk("err_w0_pready", 32'(pix_ready_o), 32'd0);
        tick();
        chk("err_w0_clear",  32'(err_o),       32'd0);
        chk("err_w0_busy2",  32'(busy_o),      32'd0);
        cfg_width_i  = W_W'(4);
        cfg_height_i = H_W'(MAX_HEIGHT + 1);
        start_i      = 1'b1;
        tick();
        start_i = 1'b0;
        chk("err_h_pulse",  32'(err_o),       32'd1);
        chk("err_h_busy",   32'(busy_o),      32'd0);
        chk("err_h_pready", 32'(pix_ready_o), 32'd0);
        tick();
        chk("err_h_clear",  32'(err_o),       32'd0);

        // start re-pulsed mid-frame must be ignored
        run_frame(8, 2, 0, 8'h20, 4, 0);

        // asynchronous reset after 5 of 16 beats
        run_frame(4, 4, 0, 8'h40, -1, 5);
        arst_i = 1'b1;
        #1;
        chk_idle("async_reset");
        tick();
        tick();
        arst_i = 1'b0;
        tick();
        chk_idle("after_abort");

        run_frame(2, 2, 0, 8'h80, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
